fifo_unpacker: RTL and testbench

- Read-side engine for the team's level-sensitive FIFO (`fifo_empty` / `data_o` / `drop` interface).
- Pops one wide entry at a time and emits it as DATA_WIDTH/OUT_WIDTH narrow chunks on a valid/ready stream.
- Sits between a FIFO and a narrow consumer (UART TX, SPI master, byte bus).
- Owns the FIFO's `drop` line; no other agent may drive it.

---
 rtl/fifo_unpacker_pkg.sv | 13 +
 rtl/fifo_unpacker.sv | 117 +++++++++++
 tb/tb_fifo_unpacker.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_unpacker_pkg.sv
// Shared definitions for fifo_unpacker.
// Holds the state encodings of the unpacker FSM (IDLE=0, SEND=1).
package fifo_unpacker_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_SEND = 1'b1;

   typedef enum logic {
      StIdle = ST_IDLE,
      StSend = ST_SEND
   } state_e;

endpackage

// File: rtl/fifo_unpacker.sv
// fifo_unpacker: read-side engine for the level-sensitive FIFO.
// Pops one DATA_WIDTH entry at a time and emits it as CHUNKS narrow OUT_WIDTH chunks on a
// valid/ready stream, least- or most-significant chunk first.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset; discards any partial word
//   enable      permits fetching new entries; a word in progress always completes
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO head entry
//   fifo_drop   one-cycle pulse per consumed entry (registered); sole driver of FIFO drop
//   out_data    current chunk (zero while idle)
//   out_valid   out_data is valid
//   out_ready   consumer accepts on out_valid && out_ready at a rising edge
//   out_last    final chunk of the current entry, qualified by out_valid
//   busy        an entry is held
module fifo_unpacker
   import fifo_unpacker_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter bit          LSB_FIRST  = 1'b1,
   parameter int unsigned CHUNKS     = DATA_WIDTH / OUT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_drop,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy
);

   localparam int unsigned CntW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(CHUNKS - 1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  drop_q, drop_d;

   logic                  fetch;
   logic                  last;
   logic [CntW-1:0]       sel;
   logic [DATA_WIDTH-1:0] shifted;

   assign fetch = enable && !fifo_empty;
   assign last  = (cnt_q == LastCnt);

   // Chunk select by shifting; sel never exceeds CHUNKS-1.
   always_comb begin
      if (LSB_FIRST) begin
         sel = cnt_q;
      end else begin
         sel = LastCnt - cnt_q;
      end
      shifted = shift_q >> (32'(sel) * OUT_WIDTH);
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      drop_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fetch) begin
               state_d = StSend;
               shift_d = fifo_data;
               cnt_d   = '0;
               drop_d  = 1'b1;
            end
         end
         StSend: begin
            if (out_ready) begin
               if (!last) begin
                  cnt_d = cnt_q + 1'b1;
               end else if (fetch && !drop_q) begin
                  // fifo_empty/fifo_data are stale while our drop is in flight, so a
                  // back-to-back fetch is only taken once the pop has landed.
                  shift_d = fifo_data;
                  cnt_d   = '0;
                  drop_d  = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   assign fifo_drop = drop_q;
   assign out_valid = (state_q == StSend);
   assign busy      = (state_q == StSend);
   assign out_last  = (state_q == StSend) && last;
   assign out_data  = (state_q == StSend) ? shifted[OUT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: three instances (LSB-first 32/8, MSB-first 32/8, single-chunk 8/8),
// each fed by a queue-based FIFO model, with a per-instance scoreboard of expected chunks.
module tb_fifo_unpacker;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   typedef struct {
      logic       en;
      logic       rdy;
      logic       valid;
      logic [7:0] data;
      logic       last;
      logic       drop;
      logic       busy;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic enable;
   logic ready;

   logic        f_empty [3];
   logic [31:0] f_data  [3];
   logic        f_drop  [3];
   logic [7:0]  o_data  [3];
   logic        o_valid [3];
   logic        o_last  [3];
   logic        o_busy  [3];

   logic [31:0] fq [3][$];
   exp_t        sb [3][$];

   int   n_vec = 0;
   int   n_err = 0;
   int   drops      [3];
   logic pend_drop  [3];
   logic prev_drop  [3];
   logic prev_stall [3];
   logic [7:0] prev_data [3];
   logic prev_last  [3];

   fifo_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .enable(enable),
      .fifo_empty(f_empty[0]), .fifo_data(f_data[0]), .fifo_drop(f_drop[0]),
      .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(ready),
      .out_last(o_last[0]), .busy(o_busy[0])
   );

   fifo_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .enable(enable),
      .fifo_empty(f_empty[1]), .fifo_data(f_data[1]), .fifo_drop(f_drop[1]),
      .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(ready),
      .out_last(o_last[1]), .busy(o_busy[1])
   );

   fifo_unpacker #(.DATA_WIDTH(8), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_one (
      .clk(clk), .rst(rst), .enable(enable),
      .fifo_empty(f_empty[2]), .fifo_data(f_data[2][7:0]), .fifo_drop(f_drop[2]),
      .out_data(o_data[2]), .out_valid(o_valid[2]), .out_ready(ready),
      .out_last(o_last[2]), .busy(o_busy[2])
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic refresh(input int id);
      f_empty[id] <= (fq[id].size() == 0);
      f_data[id]  <= (fq[id].size() != 0) ? fq[id][0] : 32'd0;
   endtask

   // Expected chunks derived by plain shifting, independent of the DUT's select logic.
   task automatic sb_fill(input int id, input logic [31:0] word);
      logic [31:0] w;
      exp_t        e;
      w = word;
      if (id == 2) begin
         e.data = w[7:0];
         e.last = 1'b1;
         sb[id].push_back(e);
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (id == 1) begin
               e.data = w[31:24];
               w = w << 8;
            end else begin
               e.data = w[7:0];
               w = w >> 8;
            end
            e.last = (k == 3);
            sb[id].push_back(e);
         end
      end
   endtask

   task automatic push(input int id, input logic [31:0] word);
      fq[id].push_back(word);
      refresh(id);
      sb_fill(id, word);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int id, input int budget);
      int n;
      n = 0;
      while (!o_valid[id] && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("wait_valid[%0d]", id), 32'(o_valid[id]), 32'd1);
   endtask

   task automatic wait_idle(input int id, input int budget);
      int n;
      n = 0;
      while (o_busy[id] && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("wait_idle[%0d]", id), 32'(o_busy[id]), 32'd0);
   endtask

   // Monitor at the falling edge, FIFO pops at the rising edge.
   task automatic bg();
      exp_t e;
      forever begin
         @(negedge clk);
         for (int id = 0; id < 3; id++) begin
            pend_drop[id] = f_drop[id];
            if (rst) begin
               prev_stall[id] = 1'b0;
               prev_drop[id]  = 1'b0;
               continue;
            end
            if (f_drop[id]) begin
               drops[id]++;
               check($sformatf("drop_adjacent[%0d]", id), 32'(prev_drop[id]), 32'd0);
            end
            prev_drop[id] = f_drop[id];
            if (prev_stall[id]) begin
               check($sformatf("hold_valid[%0d]", id), 32'(o_valid[id]), 32'd1);
               check($sformatf("hold_data[%0d]", id), 32'(o_data[id]), 32'(prev_data[id]));
               check($sformatf("hold_last[%0d]", id), 32'(o_last[id]), 32'(prev_last[id]));
            end
            if (o_valid[id] && ready) begin
               if (sb[id].size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL chunk[%0d]: got %h, expected no chunk", id, o_data[id]);
               end else begin
                  e = sb[id].pop_front();
                  check($sformatf("chunk_data[%0d]", id), 32'(o_data[id]), 32'(e.data));
                  check($sformatf("chunk_last[%0d]", id), 32'(o_last[id]), 32'(e.last));
               end
            end
            prev_stall[id] = o_valid[id] && !ready;
            prev_data[id]  = o_data[id];
            prev_last[id]  = o_last[id];
         end
         @(posedge clk);
         for (int id = 0; id < 3; id++) begin
            if (pend_drop[id]) begin
               check($sformatf("fifo_underflow[%0d]", id), 32'(fq[id].size() != 0), 32'd1);
               if (fq[id].size() != 0) void'(fq[id].pop_front());
               refresh(id);
            end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tv [6];
      int   nv;
      int   consec;
      logic pv;
      logic [15:0] pat;

      rst    = 1'b1;
      enable = 1'b0;
      ready  = 1'b0;
      for (int id = 0; id < 3; id++) begin
         drops[id]      = 0;
         pend_drop[id]  = 1'b0;
         prev_drop[id]  = 1'b0;
         prev_stall[id] = 1'b0;
         prev_data[id]  = 8'h00;
         prev_last[id]  = 1'b0;
         refresh(id);
      end
      fork
         bg();
      join_none

      // Reset state
      step();
      step();
      for (int id = 0; id < 3; id++) begin
         check($sformatf("rst_valid[%0d]", id), 32'(o_valid[id]), 32'd0);
         check($sformatf("rst_drop[%0d]", id), 32'(f_drop[id]), 32'd0);
         check($sformatf("rst_busy[%0d]", id), 32'(o_busy[id]), 32'd0);
         check($sformatf("rst_last[%0d]", id), 32'(o_last[id]), 32'd0);
         check($sformatf("rst_data[%0d]", id), 32'(o_data[id]), 32'd0);
      end
      rst = 1'b0;
      step();

      // Single word LSB-first, ready high: cycle-exact table
      tv[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b1, 1'b1, 8'hDD, 1'b0, 1'b1, 1'b1};
      tv[2] = '{1'b1, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1};
      tv[3] = '{1'b1, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1};
      tv[4] = '{1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1};
      tv[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      drops[0] = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         if (i == 0) push(0, 32'hAABBCCDD);
         enable = tv[i].en;
         ready  = tv[i].rdy;
         @(negedge clk);
         check($sformatf("t1[%0d].valid", i), 32'(o_valid[0]), 32'(tv[i].valid));
         check($sformatf("t1[%0d].last", i), 32'(o_last[0]), 32'(tv[i].last));
         check($sformatf("t1[%0d].drop", i), 32'(f_drop[0]), 32'(tv[i].drop));
         check($sformatf("t1[%0d].busy", i), 32'(o_busy[0]), 32'(tv[i].busy));
         if (tv[i].valid) begin
            check($sformatf("t1[%0d].data", i), 32'(o_data[0]), 32'(tv[i].data));
         end
      end
      step();
      check("t1_fifo_empty", 32'(fq[0].size()), 32'd0);
      check("t1_sb_empty", 32'(sb[0].size()), 32'd0);
      check("t1_drops", 32'(drops[0]), 32'd1);

      // MSB-first with backpressure
      drops[1] = 0;
      pat = 16'b1001_0100_1101_1111;
      push(1, 32'h12345678);
      for (int i = 0; i < 16; i++) begin
         ready = pat[15-i];
         step();
      end
      ready = 1'b1;
      wait_idle(1, 50);
      step();
      check("t2_sb_empty", 32'(sb[1].size()), 32'd0);
      check("t2_drops", 32'(drops[1]), 32'd1);

      // Back-to-back words, no bubble
      drops[0] = 0;
      ready = 1'b1;
      push(0, 32'h11111111);
      push(0, 32'h22222222);
      wait_valid(0, 20);
      nv = 0;
      while (o_valid[0] && nv < 40) begin
         nv++;
         @(negedge clk);
      end
      check("t3_run_length", 32'(nv), 32'd8);
      step();
      check("t3_drops", 32'(drops[0]), 32'd2);
      check("t3_sb_empty", 32'(sb[0].size()), 32'd0);

      // enable dropped during chunk 2
      push(0, 32'hDEADBEEF);
      push(0, 32'h01020304);
      step();
      step();
      enable = 1'b0;
      wait_idle(0, 20);
      step();
      step();
      step();
      check("t4_busy_held_off", 32'(o_busy[0]), 32'd0);
      check("t4_fifo_waiting", 32'(fq[0].size()), 32'd1);
      check("t4_sb_pending", 32'(sb[0].size()), 32'd4);
      enable = 1'b1;
      wait_valid(0, 20);
      wait_idle(0, 20);
      step();
      check("t4_fifo_empty", 32'(fq[0].size()), 32'd0);
      check("t4_sb_empty", 32'(sb[0].size()), 32'd0);

      // Async reset mid-word
      push(0, 32'hCAFEF00D);
      push(0, 32'h0BADBEEF);
      step();
      step();
      #1;
      rst = 1'b1;
      #1;
      check("t5_rst_valid", 32'(o_valid[0]), 32'd0);
      check("t5_rst_drop", 32'(f_drop[0]), 32'd0);
      check("t5_rst_busy", 32'(o_busy[0]), 32'd0);
      check("t5_fifo_left", 32'(fq[0].size()), 32'd1);
      sb[0].delete();
      for (int k = 0; k < fq[0].size(); k++) sb_fill(0, fq[0][k]);
      step();
      rst = 1'b0;
      wait_valid(0, 20);
      check("t5_first_chunk", 32'(o_data[0]), 32'h000000EF);
      wait_idle(0, 20);
      step();
      check("t5_sb_empty", 32'(sb[0].size()), 32'd0);

      // Single-chunk configuration
      drops[2] = 0;
      push(2, 32'h01);
      push(2, 32'h02);
      push(2, 32'h03);
      nv = 0;
      consec = 0;
      pv = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (o_valid[2]) begin
            nv++;
            if (pv) consec++;
         end
         pv = o_valid[2];
      end
      step();
      check("t6_valid_count", 32'(nv), 32'd3);
      check("t6_consecutive", 32'(consec), 32'd0);
      check("t6_drops", 32'(drops[2]), 32'd3);
      check("t6_sb_empty", 32'(sb[2].size()), 32'd0);

      for (int id = 0; id < 3; id++) begin
         check($sformatf("final_sb[%0d]", id), 32'(sb[id].size()), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
